// File: rtl/led_symbol_sequencer_if.sv
// Letter-code input stream: valid/ready handshake between message source and LED sequencer.
interface led_symbol_sequencer_if #(
  parameter int unsigned CODE_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/led_symbol_sequencer.sv
// Buffers letter codes in a FIFO and plays each as an LED ON pulse of (code+1)
// time units followed by a fixed OFF gap.
module led_symbol_sequencer #(
  parameter int unsigned CODE_W    = 5,
  parameter int unsigned MAX_CODE  = 25,
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned GAP_UNITS = 1,
  parameter int unsigned DEPTH     = 16,
  parameter bit          LED_POL   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  led_symbol_sequencer_if.slave    in_if,
  input  logic                     flush,
  output logic                     led,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned CNT_RAW = $clog2((MAX_CODE + 1) * TICK_DIV);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TICK = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_UNITS * TICK_DIV - 1);
  localparam logic LED_ACT   = LED_POL;
  localparam logic LED_INACT = ~LED_POL;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              led_q, led_d;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              in_ready_q;
  logic              err_q;

  logic              push, legal, wr, pop, empty;
  logic [CNT_W-1:0]  dur;

  // Illegal codes complete the handshake but never reach the FIFO.
  assign push  = in_if.in_valid & in_ready_q & ~flush;
  assign legal = 32'(in_if.in_code) <= MAX_CODE;
  assign wr    = push & legal;
  assign empty = (level_q == '0);
  assign dur   = (CNT_W'(mem_q[rd_ptr_q]) + CNT_ONE) * CNT_TICK - CNT_ONE;

  assign level_d = flush ? '0 : level_q + LW'(wr) - LW'(pop);

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in_if.in_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q      <= push & ~legal;
      level_q    <= level_d;
      in_ready_q <= (level_d != LW'(DEPTH));
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_q   <= LED_INACT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  // GAP chains directly into ON when more symbols are queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_ON;
            cnt_d   = dur;
          end
        end
        S_ON: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (!empty) begin
            pop     = 1'b1;
            state_d = S_ON;
            cnt_d   = dur;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_d = ((state_q == S_ON) && !flush) ? LED_ACT : LED_INACT;
    busy  = (state_q != S_IDLE) || !empty;
  end

  assign led            = led_q;
  assign level          = level_q;
  assign err            = err_q;
  assign in_if.in_ready = in_ready_q;

endmodule

// File: tb/tb_led_symbol_sequencer.sv
// Scoreboard bench: stimulus queues expected pulse/gap lengths, a forked monitor
// measures LED pulses and err strobes on the falling clock edge.
module tb_led_symbol_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       led;
  logic       busy;
  logic [4:0] level;
  logic       err;

  led_symbol_sequencer_if #(.CODE_W(5)) bus_if ();

  led_symbol_sequencer #(
    .CODE_W   (5),
    .MAX_CODE (25),
    .TICK_DIV (4),
    .GAP_UNITS(1),
    .DEPTH    (16),
    .LED_POL  (1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .in_if  (bus_if),
    .flush  (flush),
    .led    (led),
    .busy   (busy),
    .level  (level),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int on_len;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   err_total = 0;
  int   err_seen  = 0;
  int   abort_req = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp_on < 0 marks an illegal code that must strobe err instead of playing.
  task automatic push(input int code, input int exp_on, input int exp_gap);
    int t = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_code  = 5'(code);
    while (!bus_if.in_ready && t < 500) begin
      step();
      t++;
    end
    if (!bus_if.in_ready) chk("push_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    if (exp_on < 0) err_total++;
    else exp_q.push_back('{exp_on, exp_gap});
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_led(input int limit);
    int n = 0;
    while (!led && n < limit) begin
      step();
      n++;
    end
    if (!led) chk("led_timeout", 0, 1);
  endtask

  task automatic abort_expect();
    abort_req++;
    exp_q.delete();
  endtask

  task automatic mon_loop();
    int   on_cnt   = 0;
    int   low_cnt  = -1;
    int   seen_ab  = 0;
    bit   in_pulse = 1'b0;
    bit   skip     = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("level_max", int'(level <= 5'd16), 1);
      if (err) begin
        chk("err_expected", int'(err_seen < err_total), 1);
        err_seen++;
      end
      if (seen_ab != abort_req) begin
        seen_ab  = abort_req;
        in_pulse = 1'b0;
        skip     = 1'b1;
        low_cnt  = -1;
      end
      if (skip) begin
        if (!led) skip = 1'b0;
      end else if (led) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          on_cnt   = 0;
          if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
          else if (exp_q[0].gap >= 0) chk("gap_len", low_cnt, exp_q[0].gap);
        end
        on_cnt++;
      end else begin
        if (in_pulse) begin
          in_pulse = 1'b0;
          low_cnt  = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("on_len", on_cnt, e.on_len);
          end
        end
        if (low_cnt >= 0) low_cnt++;
      end
    end
  endtask

  initial begin
    int n;
    int rdy;
    int saw_not_ready;

    reset_n         = 1'b0;
    flush           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_code  = '0;
    fork
      mon_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", bus_if.in_ready, 1);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    step();

    // 1: single code 0 -> ON 4, GAP 4, busy drops 9 edges after the handshake
    push(0, 4, -1);
    chk("t1_level", level, 1);
    chk("t1_busy", busy, 1);
    wait_idle(100, n);
    chk("t1_busy_fall", n, 9);
    chk("t1_led_idle", led, 0);

    // 2: codes 2,1 back-to-back -> ON 12, GAP 4, ON 8
    push(2, 12, -1);
    push(1, 8, 4);
    wait_idle(200, n);

    // 3: hold code 25 for 20 cycles; FIFO fills to 16 with one symbol already playing
    saw_not_ready = 0;
    for (int i = 0; i < 20; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_code  = 5'd25;
      rdy = int'(bus_if.in_ready);
      if (!bus_if.in_ready) saw_not_ready = 1;
      step();
      if (rdy != 0) exp_q.push_back('{104, (i == 0) ? -1 : 4});
    end
    bus_if.in_valid = 1'b0;
    chk("t3_level_full", level, 16);
    chk("t3_in_ready_low", bus_if.in_ready, 0);
    chk("t3_saw_not_ready", saw_not_ready, 1);
    chk("t3_accepted", exp_q.size(), 17);
    wait_idle(5000, n);

    // 4: illegal code 31 -> accepted, err strobe, nothing queued
    push(31, -1, -1);
    chk("t4_err_pulse", err, 1);
    chk("t4_level", level, 0);
    step();
    chk("t4_err_clear", err, 0);
    repeat (10) step();
    chk("t4_busy", busy, 0);
    chk("t4_led", led, 0);

    // 5: flush mid-ON with 3 queued and a simultaneous push
    push(4, 20, -1);
    push(5, 24, 4);
    push(6, 28, 4);
    push(7, 32, 4);
    chk("t5_level_pre", level, 3);
    wait_led(20);
    repeat (3) step();
    abort_expect();
    flush           = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_code  = 5'd9;
    step();
    flush           = 1'b0;
    bus_if.in_valid = 1'b0;
    chk("t5_led", led, 0);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", bus_if.in_ready, 1);
    repeat (10) step();
    chk("t5_push_dropped", level, 0);
    chk("t5_led_quiet", led, 0);

    // 6: reset mid-ON, then a fresh code 0 plays a full 4-clock pulse
    push(3, 16, -1);
    wait_led(20);
    repeat (2) step();
    abort_expect();
    reset_n = 1'b0;
    #1;
    chk("t6_led_async", led, 0);
    repeat (2) step();
    chk("t6_level", level, 0);
    chk("t6_busy", busy, 0);
    reset_n = 1'b1;
    step();
    push(0, 4, -1);
    wait_idle(100, n);
    chk("t6_busy_fall", n, 9);

    repeat (4) step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_count", err_seen, err_total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
